// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-ram arbiter.
// Owner encoding, default ram geometry and starvation counter width.
package ram_arb_pkg;

  typedef enum logic {
    OWNER_MEM  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  localparam int AW_DEF       = 12;
  localparam int DW_DEF       = 16;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/ram_arb_if.sv
// Request/grant ports of MEM and host, plus the ram side and stall.
// slave = arbiter view, master = pipeline/host/ram view.
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rout;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_win;

  logic          stall;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  h_req, h_we, h_addr, h_wdata,
    output h_gnt, h_rvalid, h_rdata,
    output ram_raddr, ram_wen, ram_waddr, ram_win,
    input  ram_rout,
    output stall
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output h_req, h_we, h_addr, h_wdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  ram_raddr, ram_wen, ram_waddr, ram_win,
    output ram_rout,
    input  stall
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating host-wait counter; sat_o tells the arbiter the host must win.
// Clear has priority over increment.
module arb_starve_ctr
  import ram_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C =
    STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  assign sat_o = (cnt_q >= MAX_C);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Data-ram arbiter between MEM stage and host: one access per cycle.
// RAM_ARB_STARVE_GUARD_EN enables the host starvation guard.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic      clock,
  input  logic      reset,
  ram_arb_if.slave  bus
);

  logic sat;
  logic m_gnt;
  logic h_gnt;
  logic m_hs;
  logic h_hs;

`ifdef RAM_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (bus.h_req & ~h_gnt),
    .clr_i  (h_hs),
    .sat_o  (sat)
  );
`else
  assign sat = 1'b0;
`endif

  assign m_gnt = bus.m_req & ~(bus.h_req & sat);
  assign h_gnt = bus.h_req & (~bus.m_req | sat);
  assign m_hs  = bus.m_req & m_gnt;
  assign h_hs  = bus.h_req & h_gnt;

  assign bus.m_gnt = m_gnt;
  assign bus.h_gnt = h_gnt;
  assign bus.stall = bus.m_req & ~m_gnt;

  logic          acc_valid_q, acc_valid_d;
  owner_e        acc_owner_q, acc_owner_d;
  logic          acc_we_q, acc_we_d;
  logic [AW-1:0] acc_addr_q, acc_addr_d;
  logic [DW-1:0] acc_wdata_q, acc_wdata_d;

  always_comb begin
    acc_valid_d = m_hs | h_hs;
    acc_owner_d = acc_owner_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    unique case (1'b1)
      m_hs: begin
        acc_owner_d = OWNER_MEM;
        acc_we_d    = bus.m_we;
        acc_addr_d  = bus.m_addr;
        acc_wdata_d = bus.m_wdata;
      end
      h_hs: begin
        acc_owner_d = OWNER_HOST;
        acc_we_d    = bus.h_we;
        acc_addr_d  = bus.h_addr;
        acc_wdata_d = bus.h_wdata;
      end
      default: ;
    endcase
  end

  assign bus.ram_raddr = acc_addr_q;
  assign bus.ram_waddr = acc_addr_q;
  assign bus.ram_win   = acc_wdata_q;
  assign bus.ram_wen   = acc_valid_q & acc_we_q;

  logic          rd_done;
  logic          m_rvalid_q, m_rvalid_d;
  logic          h_rvalid_q, h_rvalid_d;
  logic [DW-1:0] m_rdata_q, m_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;

  assign rd_done = acc_valid_q & ~acc_we_q;

  always_comb begin
    m_rvalid_d = rd_done & (acc_owner_q == OWNER_MEM);
    h_rvalid_d = rd_done & (acc_owner_q == OWNER_HOST);
    m_rdata_d  = m_rvalid_d ? bus.ram_rout : m_rdata_q;
    h_rdata_d  = h_rvalid_d ? bus.ram_rout : h_rdata_q;
  end

  assign bus.m_rvalid = m_rvalid_q;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.h_rvalid = h_rvalid_q;
  assign bus.h_rdata  = h_rdata_q;

  // Reset drops any in-flight access, suppressing its write and rvalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_valid_q <= 1'b0;
      acc_owner_q <= OWNER_MEM;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      m_rvalid_q  <= 1'b0;
      h_rvalid_q  <= 1'b0;
      m_rdata_q   <= '0;
      h_rdata_q   <= '0;
    end else begin
      acc_valid_q <= acc_valid_d;
      acc_owner_q <= acc_owner_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      m_rvalid_q  <= m_rvalid_d;
      h_rvalid_q  <= h_rvalid_d;
      m_rdata_q   <= m_rdata_d;
      h_rdata_q   <= h_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a ram model and read scoreboard.
// Expectations follow RAM_ARB_STARVE_GUARD_EN the same way as the design.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int SMAX = 4;

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  ram_arb_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] mdl [0:4095];

  assign bus.ram_rout = mem[bus.ram_raddr];

  always @(posedge clock) begin
    if (bus.ram_wen) mem[bus.ram_waddr] = bus.ram_win;
  end

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   scnt = 0;
  int   hg_cnt = 0;
  int   st_cnt = 0;
  bit   exp_wen = 1'b0;
  exp_t mq[$];
  exp_t hq[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(bit req, bit we,
                       logic [AW-1:0] a, logic [DW-1:0] d);
    bus.m_req   = req;
    bus.m_we    = we;
    bus.m_addr  = a;
    bus.m_wdata = d;
  endtask

  task automatic set_h(bit req, bit we,
                       logic [AW-1:0] a, logic [DW-1:0] d);
    bus.h_req   = req;
    bus.h_we    = we;
    bus.h_addr  = a;
    bus.h_wdata = d;
  endtask

  // One clock: check this cycle at negedge, model the edge, return at +1.
  task automatic cycle();
    bit sat;
    bit gm;
    bit gh;
    @(negedge clock);
    chk("ram_wen", bus.ram_wen, exp_wen);
    if (mq.size() > 0 && mq[0].due == cyc) begin
      chk("m_rvalid", bus.m_rvalid, 1);
      chk("m_rdata", bus.m_rdata, mq[0].data);
      void'(mq.pop_front());
    end else begin
      chk("m_rvalid", bus.m_rvalid, 0);
    end
    if (hq.size() > 0 && hq[0].due == cyc) begin
      chk("h_rvalid", bus.h_rvalid, 1);
      chk("h_rdata", bus.h_rdata, hq[0].data);
      void'(hq.pop_front());
    end else begin
      chk("h_rvalid", bus.h_rvalid, 0);
    end
    sat = GUARD && (scnt == SMAX);
    gm  = bus.m_req && !(bus.h_req && sat);
    gh  = bus.h_req && (!bus.m_req || sat);
    chk("m_gnt", bus.m_gnt, gm);
    chk("h_gnt", bus.h_gnt, gh);
    chk("stall", bus.stall, bus.m_req && !gm);
    if (bus.h_gnt === 1'b1) hg_cnt++;
    if (bus.stall === 1'b1) st_cnt++;
    exp_wen = 1'b0;
    if (gm) begin
      if (bus.m_we) begin
        mdl[bus.m_addr] = bus.m_wdata;
        exp_wen = 1'b1;
      end else begin
        mq.push_back('{mdl[bus.m_addr], cyc + 2});
      end
    end else if (gh) begin
      if (bus.h_we) begin
        mdl[bus.h_addr] = bus.h_wdata;
        exp_wen = 1'b1;
      end else begin
        hq.push_back('{mdl[bus.h_addr], cyc + 2});
      end
    end
    @(posedge clock);
    cyc++;
    if (gh) scnt = 0;
    else if (bus.h_req && scnt < SMAX) scnt++;
    #1;
  endtask

  initial begin
    set_m(0, 0, '0, '0);
    set_h(0, 0, '0, '0);
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      mdl[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'hC000 + 16'(i);
      mdl[i] = 16'hC000 + 16'(i);
    end
    #1 reset = 1'b0;
    #2;
    chk("rst_m_rvalid", bus.m_rvalid, 0);
    chk("rst_h_rvalid", bus.h_rvalid, 0);
    chk("rst_m_rdata", bus.m_rdata, 0);
    chk("rst_h_rdata", bus.h_rdata, 0);
    chk("rst_ram_wen", bus.ram_wen, 0);
    bus.m_req = 1'b1;
    bus.h_req = 1'b1;
    #1;
    chk("rst_m_gnt", bus.m_gnt, 1);
    chk("rst_h_gnt", bus.h_gnt, 0);
    bus.m_req = 1'b0;
    bus.h_req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    // MEM write then read of the same address
    set_m(1, 1, 12'h0A5, 16'h1234);
    cycle();
    set_m(1, 0, 12'h0A5, 16'h0000);
    cycle();
    set_m(0, 0, '0, '0);
    repeat (3) cycle();
    chk("t1_mem", mem[12'h0A5], 16'h1234);

    // Host write then read with MEM idle
    set_h(1, 1, 12'h100, 16'hBEEF);
    cycle();
    set_h(1, 0, 12'h100, 16'h0000);
    cycle();
    set_h(0, 0, '0, '0);
    repeat (3) cycle();

    // Both ports requesting continuously
    hg_cnt = 0;
    st_cnt = 0;
    set_m(1, 0, 12'h001, '0);
    set_h(1, 0, 12'h100, '0);
    repeat (100) cycle();
    set_m(0, 0, '0, '0);
    set_h(0, 0, '0, '0);
    repeat (3) cycle();
    chk("t3_host_grants", hg_cnt, GUARD ? 20 : 0);
    chk("t3_stall_cycles", st_cnt, GUARD ? 20 : 0);

    // Reset right after a MEM write handshake
    set_m(1, 1, 12'h200, 16'hDEAD);
    cycle();
    set_m(0, 0, '0, '0);
    reset = 1'b0;
    #1;
    chk("t5_wen_forced", bus.ram_wen, 0);
    mdl[12'h200] = 16'h0000;
    exp_wen = 1'b0;
    mq.delete();
    hq.delete();
    scnt = 0;
    repeat (2) cycle();
    reset = 1'b1;
    chk("t5_mem", mem[12'h200], 16'h0000);
    set_m(1, 0, 12'h200, '0);
    cycle();
    set_m(0, 0, '0, '0);
    repeat (3) cycle();

    // MEM streams 8 reads back to back
    for (int i = 0; i < 8; i++) begin
      set_m(1, 0, 12'(i), '0);
      cycle();
    end
    set_m(0, 0, '0, '0);
    repeat (4) cycle();

    chk("drain_m", mq.size(), 0);
    chk("drain_h", hq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
